// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter slice.
package dmem_pkg;

   localparam int unsigned DMEM_ADDR_W = 16;
   localparam int unsigned DMEM_DATA_W = 16;
   localparam int unsigned DMEM_NPORTS = 2;

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StAccess = 2'd1,
      StResp   = 2'd2
   } dmem_state_e;

   typedef struct packed {
      logic                   we;
      logic                   memc;
      logic [DMEM_ADDR_W-1:0] addr;
      logic [DMEM_DATA_W-1:0] wdata;
      logic                   id;
   } dmem_cmd_t;

   function automatic logic addr_oor(input logic [DMEM_ADDR_W-1:0] addr,
                                     input int unsigned mem_bytes);
      return {16'b0, addr} >= mem_bytes;
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: masked requests, pointer favours the last non-winner.
module rr_arb2
   import dmem_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic [DMEM_NPORTS-1:0] req_i,
   input  logic [DMEM_NPORTS-1:0] mask_i,
   input  logic                   take_i,
   output logic [DMEM_NPORTS-1:0] gnt_o,
   output logic                   valid_o
);

   logic                   ptr_q, ptr_d;
   logic [DMEM_NPORTS-1:0] eff_req;
   logic                   win_id;

   always_comb begin
      eff_req = req_i & ~mask_i;
      valid_o = |eff_req;
      win_id  = (eff_req == 2'b11) ? ptr_q : eff_req[1];
      gnt_o   = 2'b00;
      if (valid_o) begin
         gnt_o = win_id ? 2'b10 : 2'b01;
      end
      ptr_d = ptr_q;
      if (take_i && valid_o) begin
         ptr_d = ~win_id;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q <= 1'b0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Serialises two requesters onto a single-port data memory with range checking.
module dmem_arbiter
   import dmem_pkg::*;
#(
   parameter int unsigned MEM_BYTES = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        p0_req_i,
   input  logic        p0_we_i,
   input  logic        p0_memc_i,
   input  logic [15:0] p0_addr_i,
   input  logic [15:0] p0_wdata_i,
   output logic        p0_ack_o,
   output logic [15:0] p0_rdata_o,
   output logic        p0_err_o,
   input  logic        p1_req_i,
   input  logic        p1_we_i,
   input  logic        p1_memc_i,
   input  logic [15:0] p1_addr_i,
   input  logic [15:0] p1_wdata_i,
   output logic        p1_ack_o,
   output logic [15:0] p1_rdata_o,
   output logic        p1_err_o,
   output logic        mem_wmem_o,
   output logic [15:0] mem_addr_o,
   output logic [15:0] mem_wdata_o,
   output logic        mem_memc_o,
   input  logic [15:0] mem_rdata_i,
   output logic        busy_o
);

   dmem_state_e            state_q;
   dmem_cmd_t              cmd_q, win_cmd;
   logic                   oor_q, win_oor;
   logic                   wmem_q;
   logic [DMEM_NPORTS-1:0] ack_q;
   logic                   err_q;
   logic                   rd_ok_q;

   logic [DMEM_NPORTS-1:0] arb_req, arb_mask, arb_gnt;
   logic                   arb_valid, arb_take, start;

   assign arb_req = {p1_req_i, p0_req_i};

   // The owner of the response cycle may not win the arbitration held in that cycle.
   always_comb begin
      arb_mask = 2'b00;
      if (state_q == StResp) begin
         arb_mask = cmd_q.id ? 2'b10 : 2'b01;
      end
      arb_take = (state_q == StIdle) || (state_q == StResp);
      start    = arb_take && arb_valid;
   end

   rr_arb2 u_arb (
      .clk     (clk),
      .rst     (rst),
      .req_i   (arb_req),
      .mask_i  (arb_mask),
      .take_i  (arb_take),
      .gnt_o   (arb_gnt),
      .valid_o (arb_valid)
   );

   always_comb begin
      unique case (arb_gnt)
         2'b10:   win_cmd = '{we: p1_we_i, memc: p1_memc_i, addr: p1_addr_i,
                              wdata: p1_wdata_i, id: 1'b1};
         default: win_cmd = '{we: p0_we_i, memc: p0_memc_i, addr: p0_addr_i,
                              wdata: p0_wdata_i, id: 1'b0};
      endcase
      win_oor = addr_oor(win_cmd.addr, MEM_BYTES);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         cmd_q   <= '0;
         oor_q   <= 1'b0;
         wmem_q  <= 1'b0;
         ack_q   <= '0;
         err_q   <= 1'b0;
         rd_ok_q <= 1'b0;
      end else begin
         wmem_q <= 1'b0;
         ack_q  <= '0;
         err_q  <= 1'b0;
         if (start) begin
            cmd_q  <= win_cmd;
            oor_q  <= win_oor;
            wmem_q <= win_cmd.we && !win_oor;
         end
         unique case (state_q)
            StIdle: begin
               if (start) state_q <= StAccess;
            end
            StAccess: begin
               ack_q   <= cmd_q.id ? 2'b10 : 2'b01;
               err_q   <= oor_q;
               rd_ok_q <= !cmd_q.we && !oor_q;
               state_q <= StResp;
            end
            StResp: begin
               state_q <= start ? StAccess : StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   // Read data comes straight from the memory's output register during the response cycle.
   always_comb begin
      p0_ack_o   = ack_q[0];
      p1_ack_o   = ack_q[1];
      p0_err_o   = ack_q[0] & err_q;
      p1_err_o   = ack_q[1] & err_q;
      p0_rdata_o = (ack_q[0] && rd_ok_q) ? mem_rdata_i : 16'h0000;
      p1_rdata_o = (ack_q[1] && rd_ok_q) ? mem_rdata_i : 16'h0000;
      mem_wmem_o  = wmem_q;
      mem_addr_o  = cmd_q.addr;
      mem_wdata_o = cmd_q.wdata;
      mem_memc_o  = cmd_q.memc;
      busy_o      = (state_q != StIdle);
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a 64-byte big-endian memory model.
module tb_dmem_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        p0_req = 1'b0, p0_we = 1'b0, p0_memc = 1'b0;
   logic [15:0] p0_addr = 16'h0, p0_wdata = 16'h0;
   logic        p1_req = 1'b0, p1_we = 1'b0, p1_memc = 1'b0;
   logic [15:0] p1_addr = 16'h0, p1_wdata = 16'h0;
   logic        p0_ack, p0_err, p1_ack, p1_err;
   logic [15:0] p0_rdata, p1_rdata;
   logic        mem_wmem, mem_memc, busy;
   logic [15:0] mem_addr, mem_wdata;
   logic [15:0] mem_rdata = 16'h0;

   dmem_arbiter #(.MEM_BYTES(64)) dut (
      .clk         (clk),
      .rst         (rst),
      .p0_req_i    (p0_req),
      .p0_we_i     (p0_we),
      .p0_memc_i   (p0_memc),
      .p0_addr_i   (p0_addr),
      .p0_wdata_i  (p0_wdata),
      .p0_ack_o    (p0_ack),
      .p0_rdata_o  (p0_rdata),
      .p0_err_o    (p0_err),
      .p1_req_i    (p1_req),
      .p1_we_i     (p1_we),
      .p1_memc_i   (p1_memc),
      .p1_addr_i   (p1_addr),
      .p1_wdata_i  (p1_wdata),
      .p1_ack_o    (p1_ack),
      .p1_rdata_o  (p1_rdata),
      .p1_err_o    (p1_err),
      .mem_wmem_o  (mem_wmem),
      .mem_addr_o  (mem_addr),
      .mem_wdata_o (mem_wdata),
      .mem_memc_o  (mem_memc),
      .mem_rdata_i (mem_rdata),
      .busy_o      (busy)
   );

   always #5 clk = ~clk;

   // Memory: byte i starts as i^C3; words are big-endian at the even address.
   logic [7:0] mem [64];
   logic       mem_ready = 1'b0;
   always @(posedge clk) begin
      if (!mem_ready) begin
         for (int i = 0; i < 64; i++) mem[i] <= 8'(i) ^ 8'hC3;
         mem_ready <= 1'b1;
      end else if (mem_wmem) begin
         if (mem_memc) begin
            mem[{mem_addr[5:1], 1'b0}] <= mem_wdata[15:8];
            mem[{mem_addr[5:1], 1'b1}] <= mem_wdata[7:0];
         end else begin
            mem[mem_addr[5:0]] <= mem_wdata[7:0];
         end
      end else begin
         mem_rdata <= mem_memc ? {mem[{mem_addr[5:1], 1'b0}], mem[{mem_addr[5:1], 1'b1}]}
                               : {8'h00, mem[mem_addr[5:0]]};
      end
   end

   typedef struct packed {
      logic        port;
      logic        err;
      logic [15:0] rdata;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0, passed = 0;
   int   cyc = 0, last_ack = -1, gap_exp = 0, ack_cnt = 0;
   logic gap_chk = 1'b0, both_seen = 1'b0, oor_wr_seen = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act === req) passed++;
      else $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
   endtask

   task automatic push(input logic port, input logic err, input logic [15:0] rdata);
      exp_t e;
      e.port  = port;
      e.err   = err;
      e.rdata = rdata;
      exp_q.push_back(e);
   endtask

   // Monitor: pops the scoreboard on every ack.
   initial begin
      exp_t        e;
      logic        a, er;
      logic [15:0] rd;
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst) begin
            if (p0_ack && p1_ack) both_seen = 1'b1;
            if (mem_wmem && mem_addr >= 16'd64) oor_wr_seen = 1'b1;
            for (int p = 0; p < 2; p++) begin
               a  = (p == 0) ? p0_ack : p1_ack;
               er = (p == 0) ? p0_err : p1_err;
               rd = (p == 0) ? p0_rdata : p1_rdata;
               if (a) begin
                  ack_cnt++;
                  if (gap_chk && last_ack >= 0) check("ack_gap", cyc - last_ack, gap_exp);
                  last_ack = cyc;
                  if (exp_q.size() == 0) begin
                     total++;
                     $display("FAIL unexpected_ack: port %0d acked, none required", p);
                  end else begin
                     e = exp_q.pop_front();
                     check("ack_port", p, e.port);
                     check("ack_err", er, e.err);
                     check("ack_rdata", rd, e.rdata);
                  end
               end
            end
         end
      end
   end

   // Issue one command on port p; exp_lat > 0 checks negedges from drive to ack.
   task automatic access(input int p, input logic we, input logic memc,
                         input logic [15:0] addr, input logic [15:0] wdata, input int exp_lat);
      int   n = 0;
      logic got = 1'b0;
      @(posedge clk);
      #1;
      if (p == 0) begin
         p0_we = we; p0_memc = memc; p0_addr = addr; p0_wdata = wdata; p0_req = 1'b1;
      end else begin
         p1_we = we; p1_memc = memc; p1_addr = addr; p1_wdata = wdata; p1_req = 1'b1;
      end
      while (!got && n < 20) begin
         @(negedge clk);
         n++;
         got = (p == 0) ? p0_ack : p1_ack;
      end
      if (!got) begin
         total++;
         $display("FAIL ack_timeout: port %0d no ack within %0d cycles", p, n);
      end else if (exp_lat > 0) begin
         check("ack_latency", n, exp_lat);
      end
      @(posedge clk);
      #1;
      if (p == 0) p0_req = 1'b0;
      else p1_req = 1'b0;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int target;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", busy, 0);
      check("rst_ack", {p1_ack, p0_ack}, 0);
      check("rst_err", {p1_err, p0_err}, 0);
      check("rst_rdata", {p1_rdata, p0_rdata}, 0);
      check("rst_wmem", mem_wmem, 0);
      check("rst_mem_bus", {mem_addr, mem_wdata, 15'h0, mem_memc}, 0);

      // Contention from reset: both held, p0 first, alternating every 2 cycles.
      push(0, 0, 16'h0); push(1, 0, 16'h0); push(0, 0, 16'h0); push(1, 0, 16'h0);
      gap_chk = 1'b1; gap_exp = 2;
      fork
         begin access(0, 1, 1, 16'h0004, 16'h1111, 0); access(0, 1, 1, 16'h0006, 16'h3333, 0); end
         begin access(1, 1, 1, 16'h0008, 16'h2222, 0); access(1, 1, 1, 16'h000A, 16'h4444, 0); end
         begin @(posedge clk); #3; rst = 1'b0; end
      join
      gap_chk = 1'b0;
      repeat (2) @(posedge clk);
      check("cont_mem", {mem[4], mem[5], mem[8], mem[9]}, 32'h11112222);
      check("cont_mem2", {mem[6], mem[7], mem[10], mem[11]}, 32'h33334444);

      // Word write then read on p0.
      push(0, 0, 16'h0);
      access(0, 1, 1, 16'h0010, 16'hA55A, 3);
      push(0, 0, 16'hA55A);
      access(0, 0, 1, 16'h0010, 16'h0000, 3);
      check("word_bytes", {mem[16], mem[17]}, 16'hA55A);
      @(negedge clk);
      check("idle_hold_bus", {mem_addr, 15'h0, mem_memc}, {16'h0010, 16'h0001});
      check("idle_wmem", mem_wmem, 0);

      // Byte write/read on p1; upper wdata byte must be ignored.
      push(1, 0, 16'h0);
      access(1, 1, 0, 16'h0021, 16'h557E, 3);
      push(1, 0, 16'h007E);
      access(1, 0, 0, 16'h0021, 16'hFFFF, 3);
      check("byte_neighbour", {mem[32], mem[33]}, 16'hE37E);

      // Range boundary: 0x3F in range, 0x40 out of range.
      push(0, 0, 16'h0);
      access(0, 1, 0, 16'h003F, 16'h009D, 3);
      push(0, 0, 16'h009D);
      access(0, 0, 0, 16'h003F, 16'h0000, 3);
      push(0, 1, 16'h0);
      access(0, 1, 1, 16'h0040, 16'hBEEF, 3);
      push(0, 1, 16'h0);
      access(0, 0, 1, 16'h0040, 16'h0000, 3);
      check("oor_mem_untouched", {mem[0], mem[1]}, 16'hC3C2);

      // Held request: regrant only after an idle cycle.
      push(0, 0, 16'hA55A); push(0, 0, 16'hA55A); push(0, 0, 16'hA55A);
      last_ack = -1; gap_chk = 1'b1; gap_exp = 3;
      target = ack_cnt + 3;
      @(posedge clk);
      #1;
      p0_we = 1'b0; p0_memc = 1'b1; p0_addr = 16'h0010; p0_req = 1'b1;
      n = 0;
      while (ack_cnt < target && n < 40) begin
         @(posedge clk);
         n++;
      end
      #1;
      p0_req = 1'b0;
      gap_chk = 1'b0;
      check("held_ack_count", ack_cnt, target);
      repeat (3) @(posedge clk);

      // Reset while a p1 write sits in ACCESS.
      @(posedge clk);
      #1;
      p1_we = 1'b1; p1_memc = 1'b1; p1_addr = 16'h0002; p1_wdata = 16'h1234; p1_req = 1'b1;
      @(posedge clk);
      #2;
      check("access_wmem", mem_wmem, 1);
      rst = 1'b1;
      #1;
      check("rst_wmem_drop", mem_wmem, 0);
      check("rst_busy_drop", busy, 0);
      p1_req = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      check("rst_mem_untouched", {mem[2], mem[3]}, 16'hC1C0);
      check("rst_no_ack_pending", exp_q.size(), 0);

      // Pointer back at p0: simultaneous requests grant p0 first.
      push(0, 0, 16'hA55A); push(1, 0, 16'h007E);
      fork
         access(0, 0, 1, 16'h0010, 16'h0000, 3);
         access(1, 0, 0, 16'h0021, 16'h0000, 5);
      join
      repeat (3) @(posedge clk);

      check("sb_drained", exp_q.size(), 0);
      check("never_both_ack", both_seen, 0);
      check("never_oor_wmem", oor_wr_seen, 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
